// File: rtl/reg_sel_sequencer_pkg.sv
// Shared definitions for the register-select sequencer: instruction format,
// opcodes, FSM state encoding and the debug view struct.
package reg_sel_sequencer_pkg;

  localparam int INSTR_W = 8;

  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int DST_HI = 5;
  localparam int DST_LO = 4;
  localparam int SRC_HI = 3;
  localparam int SRC_LO = 2;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_MOVE = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXEC_A = 3'd1,
    EXEC_B = 3'd2,
    CLEAR  = 3'd3,
    RETIRE = 3'd4
  } state_t;

  typedef struct packed {
    state_t               state;
    logic [INSTR_W-1:0]   instr;
  } dbg_t;

  function automatic logic [1:0] instr_op(input logic [INSTR_W-1:0] i);
    return i[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/reg_sel_sequencer_if.sv
// Instruction handshake and register-block control bus of the sequencer.
// Handshake: a transfer happens on a rising edge where instr_valid && instr_ready;
// instr is only sampled then, and may change freely while instr_ready is low.
interface reg_sel_sequencer_if #(
  parameter int INSTR_W = 8,
  parameter int SEL_W   = 4,
  parameter int CNT_W   = 8
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic [SEL_W-1:0]   s1;
  logic               rd_en;
  logic               wr_en;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   op_count;

  modport master (
    output instr_valid, instr,
    input  instr_ready, s1, rd_en, wr_en, busy, done, op_count
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, s1, rd_en, wr_en, busy, done, op_count
  );
endinterface

// File: rtl/reg_sel_sequencer_sel_decode.sv
// 2-bit register index to SEL_W-wide one-hot select.
module reg_sel_sequencer_sel_decode #(
  parameter int SEL_W = 4
) (
  input  logic [1:0]       idx,
  output logic [SEL_W-1:0] sel
);
  assign sel = SEL_W'(1) << idx;
endmodule

// File: rtl/reg_sel_sequencer.sv
// Micro-instruction sequencer driving the registered select bus and read/write
// strobes of the register block; one done pulse per retired instruction.
module reg_sel_sequencer
  import reg_sel_sequencer_pkg::*;
#(
  parameter int SEL_W      = 4,
  parameter int CLR_CYCLES = 3,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_sel_sequencer_if.slave  bus,
  output dbg_t                dbg
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  state_t             state;
  logic [INSTR_W-1:0] instr_q;
  logic [CLR_W-1:0]   clr_cnt;
  logic [SEL_W-1:0]   sel_src_in;
  logic [SEL_W-1:0]   sel_dst_in;
  logic [SEL_W-1:0]   sel_dst_q;
  logic               accept;

  // Phase-A selects come from the live instruction so they can be registered on
  // the accept edge; phase B uses the latched copy.
  reg_sel_sequencer_sel_decode #(.SEL_W(SEL_W)) u_dec_src_in (
    .idx (bus.instr[SRC_HI:SRC_LO]),
    .sel (sel_src_in)
  );

  reg_sel_sequencer_sel_decode #(.SEL_W(SEL_W)) u_dec_dst_in (
    .idx (bus.instr[DST_HI:DST_LO]),
    .sel (sel_dst_in)
  );

  reg_sel_sequencer_sel_decode #(.SEL_W(SEL_W)) u_dec_dst_q (
    .idx (instr_q[DST_HI:DST_LO]),
    .sel (sel_dst_q)
  );

  assign bus.instr_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign accept          = bus.instr_valid && bus.instr_ready;

  assign dbg.state = state;
  assign dbg.instr = instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      instr_q      <= '0;
      clr_cnt      <= '0;
      bus.s1       <= '0;
      bus.rd_en    <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.done     <= 1'b0;
      bus.op_count <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            instr_q <= bus.instr;
            case (instr_op(bus.instr))
              OP_LOAD: begin
                state     <= EXEC_A;
                bus.s1    <= sel_dst_in;
                bus.wr_en <= 1'b1;
              end
              OP_MOVE: begin
                state     <= EXEC_A;
                bus.s1    <= sel_src_in;
                bus.rd_en <= 1'b1;
              end
              OP_CLR: begin
                state     <= CLEAR;
                bus.s1    <= '1;
                bus.wr_en <= 1'b1;
                clr_cnt   <= CLR_W'(CLR_CYCLES - 1);
              end
              default: begin
                state  <= EXEC_A;
                bus.s1 <= '0;
              end
            endcase
          end
        end

        EXEC_A: begin
          if (instr_op(instr_q) == OP_MOVE) begin
            state     <= EXEC_B;
            bus.s1    <= sel_dst_q;
            bus.rd_en <= 1'b0;
            bus.wr_en <= 1'b1;
          end else begin
            state     <= RETIRE;
            bus.s1    <= '0;
            bus.rd_en <= 1'b0;
            bus.wr_en <= 1'b0;
            bus.done  <= 1'b1;
            if (bus.op_count != '1) bus.op_count <= bus.op_count + CNT_W'(1);
          end
        end

        EXEC_B: begin
          state     <= RETIRE;
          bus.s1    <= '0;
          bus.rd_en <= 1'b0;
          bus.wr_en <= 1'b0;
          bus.done  <= 1'b1;
          if (bus.op_count != '1) bus.op_count <= bus.op_count + CNT_W'(1);
        end

        CLEAR: begin
          if (clr_cnt == '0) begin
            state     <= RETIRE;
            bus.s1    <= '0;
            bus.wr_en <= 1'b0;
            bus.done  <= 1'b1;
            if (bus.op_count != '1) bus.op_count <= bus.op_count + CNT_W'(1);
          end else begin
            clr_cnt <= clr_cnt - CLR_W'(1);
          end
        end

        RETIRE: begin
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          bus.s1    <= '0;
          bus.rd_en <= 1'b0;
          bus.wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_sel_sequencer.sv
// Directed bench for reg_sel_sequencer: vector table of single instructions plus
// hand-written reset, back-to-back and counter-saturation sequences.
module tb_reg_sel_sequencer;
  import reg_sel_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_sel_sequencer_if #(.INSTR_W(8), .SEL_W(4), .CNT_W(8)) bus  ();
  reg_sel_sequencer_if #(.INSTR_W(8), .SEL_W(4), .CNT_W(2)) bus2 ();
  dbg_t dbg1, dbg2;

  reg_sel_sequencer #(.SEL_W(4), .CLR_CYCLES(3), .CNT_W(8)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus.slave), .dbg (dbg1)
  );

  reg_sel_sequencer #(.SEL_W(4), .CLR_CYCLES(3), .CNT_W(2)) dut_sat (
    .clk (clk), .rst_n (rst_n), .bus (bus2.slave), .dbg (dbg2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_cnt = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string           name;
    logic [7:0]      instr;
    int              n;      // cycles between accept and done
    logic [2:0][3:0] s1;     // per phase, index 0 first
    logic [2:0]      rd;
    logic [2:0]      wr;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    logic [7:0] exp_c;
    check({v.name, "_ready_pre"}, 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = v.instr;
    exp_c = (exp_cnt == 8'hff) ? exp_cnt : exp_cnt + 8'd1;
    exp_cnt = exp_c;
    exp_q.push_back(exp_c);
    step();
    for (int i = 0; i < v.n; i++) begin
      // keep valid high with junk to prove nothing is taken while busy
      bus.instr = 8'($urandom_range(0, 255));
      check($sformatf("%s_s1_p%0d", v.name, i), 32'(bus.s1), 32'(v.s1[i]));
      check($sformatf("%s_rd_p%0d", v.name, i), 32'(bus.rd_en), 32'(v.rd[i]));
      check($sformatf("%s_wr_p%0d", v.name, i), 32'(bus.wr_en), 32'(v.wr[i]));
      check($sformatf("%s_ready_p%0d", v.name, i), 32'(bus.instr_ready), 32'd0);
      check($sformatf("%s_done_p%0d", v.name, i), 32'(bus.done), 32'd0);
      step();
    end
    check({v.name, "_done"}, 32'(bus.done), 32'd1);
    check({v.name, "_s1_ret"}, 32'(bus.s1), 32'd0);
    check({v.name, "_strobes_ret"}, 32'({bus.rd_en, bus.wr_en}), 32'd0);
    check({v.name, "_busy_ret"}, 32'(bus.busy), 32'd1);
    check({v.name, "_count"}, 32'(bus.op_count), 32'(exp_q.pop_front()));
    step();
    bus.instr_valid = 1'b0;
    check({v.name, "_done_low"}, 32'(bus.done), 32'd0);
    check({v.name, "_idle"}, 32'(dbg1.state), 32'(IDLE));
  endtask

  initial begin
    vecs[0] = '{"load",      8'b01_10_00_00, 1, {4'h0, 4'h0, 4'b0100}, 3'b000, 3'b001};
    vecs[1] = '{"move",      8'b10_11_01_00, 2, {4'h0, 4'b1000, 4'b0010}, 3'b001, 3'b010};
    vecs[2] = '{"clr",       8'b11_00_00_00, 3, {4'b1111, 4'b1111, 4'b1111}, 3'b000, 3'b111};
    vecs[3] = '{"nop",       8'b00_11_10_11, 1, {4'h0, 4'h0, 4'h0}, 3'b000, 3'b000};
    vecs[4] = '{"move_same", 8'b10_01_01_10, 2, {4'h0, 4'b0010, 4'b0010}, 3'b001, 3'b010};
    vecs[5] = '{"load_r0",   8'b01_00_11_11, 1, {4'h0, 4'h0, 4'b0001}, 3'b000, 3'b001};
    vecs[6] = '{"move_3to0", 8'b10_00_11_00, 2, {4'h0, 4'b0001, 4'b1000}, 3'b001, 3'b010};

    bus.instr_valid  = 1'b0;
    bus.instr        = 8'h00;
    bus2.instr_valid = 1'b0;
    bus2.instr       = 8'h00;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s1", 32'(bus.s1), 32'd0);
    check("rst_strobes", 32'({bus.rd_en, bus.wr_en, bus.done}), 32'd0);
    check("rst_count", 32'(bus.op_count), 32'd0);
    check("rst_state", 32'(dbg1.state), 32'(IDLE));
    check("rst_latch", 32'(dbg1.instr), 32'd0);
    rst_n = 1'b1;
    step();

    // reset mid-MOVE while in EXEC_B
    bus.instr_valid = 1'b1;
    bus.instr       = 8'b10_11_01_00;
    step();
    bus.instr_valid = 1'b0;
    step();
    check("midmove_exec_b", 32'(dbg1.state), 32'(EXEC_B));
    check("midmove_s1", 32'(bus.s1), 32'b1000);
    rst_n = 1'b0;
    #1;
    check("abort_s1", 32'(bus.s1), 32'd0);
    check("abort_strobes", 32'({bus.rd_en, bus.wr_en}), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_ready", 32'(bus.instr_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("abort_no_done", 32'(bus.done), 32'd0);
    check("abort_count", 32'(bus.op_count), 32'd0);

    // table-driven single instructions
    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // back-to-back: valid held with LOAD then NOP
    bus.instr_valid = 1'b1;
    bus.instr       = 8'b01_01_00_00;
    step();
    bus.instr = 8'b00_00_00_00;
    check("b2b_load_s1", 32'(bus.s1), 32'b0010);
    check("b2b_load_wr", 32'(bus.wr_en), 32'd1);
    check("b2b_ready0", 32'(bus.instr_ready), 32'd0);
    step();
    exp_cnt = exp_cnt + 8'd1;
    check("b2b_done1", 32'(bus.done), 32'd1);
    check("b2b_ready_ret", 32'(bus.instr_ready), 32'd0);
    check("b2b_count1", 32'(bus.op_count), 32'(exp_cnt));
    step();
    check("b2b_idle_wait", 32'(dbg1.state), 32'(IDLE));
    check("b2b_done_low", 32'(bus.done), 32'd0);
    step();
    bus.instr_valid = 1'b0;
    check("b2b_nop_exec", 32'(dbg1.state), 32'(EXEC_A));
    check("b2b_nop_s1", 32'(bus.s1), 32'd0);
    check("b2b_nop_strobes", 32'({bus.rd_en, bus.wr_en}), 32'd0);
    step();
    exp_cnt = exp_cnt + 8'd1;
    check("b2b_done2", 32'(bus.done), 32'd1);
    check("b2b_count2", 32'(bus.op_count), 32'(exp_cnt));
    step();
    check("b2b_final_idle", 32'(bus.instr_ready), 32'd1);

    // saturation on the CNT_W=2 instance
    for (int k = 1; k <= 5; k++) begin
      bus2.instr_valid = 1'b1;
      bus2.instr       = 8'h00;
      step();
      bus2.instr_valid = 1'b0;
      step();
      check($sformatf("sat_done_%0d", k), 32'(bus2.done), 32'd1);
      check($sformatf("sat_count_%0d", k), 32'(bus2.op_count), (k > 3) ? 32'd3 : 32'(k));
      step();
    end
    repeat (4) step();
    check("sat_hold", 32'(bus2.op_count), 32'd3);
    check("main_untouched", 32'(bus.op_count), 32'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
